// File: rtl/des_expand_stream.sv
// Streaming DES-style E-box: G-group 4-to-6 border-duplicating expansion (or its inverse
// contraction with border checking), subkey XOR, valid/ready handshake and 2-deep output buffer.
module des_expand_stream #(
    parameter int G         = 8,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_mode,
    input  logic [6*G-1:0]       s_data,
    input  logic [6*G-1:0]       s_key,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [6*G-1:0]       m_data,
    output logic                 m_mode,
    output logic                 m_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int IN_W  = 4 * G;
    localparam int EXP_W = 6 * G;

    function automatic logic [EXP_W-1:0] expand_f(input logic [IN_W-1:0] din);
        logic [EXP_W-1:0] e;
        e = '0;
        for (int g = 0; g < G; g++) begin
            e[6*g]         = din[(4*g + IN_W - 1) % IN_W];
            e[6*g+1 +: 4]  = din[4*g +: 4];
            e[6*g+5]       = din[(4*g + 4) % IN_W];
        end
        return e;
    endfunction

    function automatic logic [IN_W-1:0] contract_f(input logic [EXP_W-1:0] x);
        logic [IN_W-1:0] r;
        r = '0;
        for (int g = 0; g < G; g++) begin
            r[4*g +: 4] = x[6*g+1 +: 4];
        end
        return r;
    endfunction

    // Border bits must match the neighbouring group's middle bits they were copied from.
    function automatic logic border_err_f(input logic [EXP_W-1:0] x);
        logic [IN_W-1:0] r;
        logic            err;
        r   = contract_f(x);
        err = 1'b0;
        for (int g = 0; g < G; g++) begin
            err = err | (x[6*g] ^ r[(4*g + IN_W - 1) % IN_W]) | (x[6*g+5] ^ r[(4*g + 4) % IN_W]);
        end
        return err;
    endfunction

    logic [EXP_W-1:0]     x_s;
    logic [EXP_W-1:0]     res_data_s;
    logic                 res_err_s;
    logic                 push_s;
    logic                 pop_s;
    logic [1:0]           cnt_r;
    logic [EXP_W-1:0]     data0_r;
    logic [EXP_W-1:0]     data1_r;
    logic                 mode0_r;
    logic                 mode1_r;
    logic                 err0_r;
    logic                 err1_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    assign x_s     = s_data ^ s_key;
    assign s_ready = (cnt_r != 2'd2);
    assign m_valid = (cnt_r != 2'd0);
    assign push_s  = s_valid && s_ready;
    assign pop_s   = m_valid && m_ready;
    assign m_data  = data0_r;
    assign m_mode  = mode0_r;
    assign m_err   = err0_r;
    assign err_cnt = err_cnt_r;

    // Input-side result for the beat currently offered.
    always_comb begin
        res_data_s = '0;
        res_err_s  = 1'b0;
        if (s_mode) begin
            res_data_s = {{(EXP_W-IN_W){1'b0}}, contract_f(x_s)};
            res_err_s  = border_err_f(x_s);
        end else begin
            res_data_s = expand_f(s_data[IN_W-1:0]) ^ s_key;
            res_err_s  = 1'b0;
        end
    end

    // Two-entry buffer with the head always held in entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 2'd0;
            data0_r <= '0;
            data1_r <= '0;
            mode0_r <= 1'b0;
            mode1_r <= 1'b0;
            err0_r  <= 1'b0;
            err1_r  <= 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        data0_r <= res_data_s;
                        mode0_r <= s_mode;
                        err0_r  <= res_err_s;
                    end else begin
                        data1_r <= res_data_s;
                        mode1_r <= s_mode;
                        err1_r  <= res_err_s;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    data0_r <= data1_r;
                    mode0_r <= mode1_r;
                    err0_r  <= err1_r;
                    data1_r <= '0;
                    mode1_r <= 1'b0;
                    err1_r  <= 1'b0;
                    cnt_r   <= cnt_r - 2'd1;
                end
                // Simultaneous push and pop only happens with one entry held.
                2'b11: begin
                    data0_r <= res_data_s;
                    mode0_r <= s_mode;
                    err0_r  <= res_err_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Saturating count of accepted beats that failed the border check.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= '0;
        end else if (push_s && res_err_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end
endmodule
